// File: rtl/alu_pkg.sv
// Shared types for the register-file ALU: opcode and controller state encodings.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_INC  = 3'b000,
        OP_DEC  = 3'b001,
        OP_NOT  = 3'b010,
        OP_AND  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_OR   = 3'b110,
        OP_LOAD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_if.sv
// Command/response bus of alu_core. Both channels are valid/ready: a transfer happens on
// a rising edge where valid and ready are both high; a source holds its payload until then.
interface alu_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4
);
    localparam int RW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [RW-1:0]    in_reg;
    logic [WIDTH-1:0] in_arg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [RW-1:0]    out_reg;
    logic             out_carry;
    logic             out_zero;

    modport master (
        output in_valid, in_op, in_reg, in_arg, out_ready,
        input  in_ready, out_valid, out_data, out_reg, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_reg, in_arg, out_ready,
        output in_ready, out_valid, out_data, out_reg, out_carry, out_zero
    );
endinterface

// File: rtl/alu_regfile.sv
// Register file: combinational read port, single synchronous write port, cleared on reset.
module alu_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(NREGS)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/alu_core.sv
// Register-file ALU with a bit-serial shifter; one command in flight, result held until taken.
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_if.slave   bus,
    output state_e o_dbg_state
);
    localparam int RW = $clog2(NREGS);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e           r_state;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_data;
    logic [RW-1:0]    r_reg;
    logic [CW-1:0]    r_cnt;
    logic             r_shl;
    logic             r_carry;
    logic             r_zero;

    op_e              w_op;
    logic [CW-1:0]    w_n_raw;
    logic [CW-1:0]    w_n;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_cy;
    logic [WIDTH-1:0] w_rd;
    logic             w_accept;
    logic             w_start_shift;
    logic             w_last;
    logic [WIDTH-1:0] w_step;
    logic             w_step_cy;
    logic             w_we;
    logic [RW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;

    alu_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (bus.in_reg),
        .o_rdata (w_rd)
    );

    // Single-cycle result; shifts with n>0 are finished by the serial path instead.
    always_comb begin
        w_op    = op_e'(bus.in_op);
        w_n_raw = bus.in_arg[CW-1:0];
        w_n     = (w_n_raw > CW'(WIDTH)) ? CW'(WIDTH) : w_n_raw;
        w_sum   = '0;
        w_res   = w_rd;
        w_cy    = 1'b0;
        case (w_op)
            OP_INC:  begin w_sum = {1'b0, w_rd} + (WIDTH+1)'(1); w_res = w_sum[WIDTH-1:0]; w_cy = w_sum[WIDTH]; end
            OP_DEC:  begin w_sum = {1'b0, w_rd} - (WIDTH+1)'(1); w_res = w_sum[WIDTH-1:0]; w_cy = w_sum[WIDTH]; end
            OP_NOT:  w_res = ~w_rd;
            OP_AND:  w_res = w_rd & bus.in_arg;
            OP_OR:   w_res = w_rd | bus.in_arg;
            OP_LOAD: w_res = bus.in_arg;
            default: w_res = w_rd;
        endcase
    end

    assign w_accept      = (r_state == ST_IDLE) && bus.in_valid;
    assign w_start_shift = ((w_op == OP_SHL) || (w_op == OP_SHR)) && (w_n != '0);
    assign w_last        = (r_state == ST_SHIFT) && (r_cnt <= CW'(1));
    assign w_step        = r_shl ? {r_work[WIDTH-2:0], 1'b0} : {1'b0, r_work[WIDTH-1:1]};
    assign w_step_cy     = r_shl ? r_work[WIDTH-1] : r_work[0];

    // The register is committed exactly on the edge that enters RESP.
    assign w_we    = (w_accept && !w_start_shift) || w_last;
    assign w_waddr = (r_state == ST_SHIFT) ? r_reg : bus.in_reg;
    assign w_wdata = (r_state == ST_SHIFT) ? w_step : w_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_data  <= '0;
            r_reg   <= '0;
            r_cnt   <= '0;
            r_shl   <= 1'b0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_reg <= bus.in_reg;
                        if (w_start_shift) begin
                            r_work  <= w_rd;
                            r_cnt   <= w_n;
                            r_shl   <= (w_op == OP_SHL);
                            r_state <= ST_SHIFT;
                        end else begin
                            r_data  <= w_res;
                            r_carry <= w_cy;
                            r_zero  <= (w_res == '0);
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work  <= w_step;
                    r_cnt   <= r_cnt - CW'(1);
                    r_carry <= w_step_cy;
                    if (w_last) begin
                        r_data  <= w_step;
                        r_zero  <= (w_step == '0);
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_RESP);
    assign bus.out_data  = r_data;
    assign bus.out_reg   = r_reg;
    assign bus.out_carry = r_carry;
    assign bus.out_zero  = r_zero;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed cases on a 16-bit/4-register core, random stream on an 8/8 core,
// both checked by a queue-based scoreboard fed from an arithmetic reference model.
module tb_alu_core;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(16), .NREGS(4)) if16 ();
    alu_if #(.WIDTH(8),  .NREGS(8)) if8 ();
    state_e dbg16, dbg8;

    alu_core #(.WIDTH(16), .NREGS(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16.slave), .o_dbg_state(dbg16)
    );
    alu_core #(.WIDTH(8), .NREGS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8.slave), .o_dbg_state(dbg8)
    );

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [31:0] exp16_q[$];
    logic [31:0] exp8_q[$];
    int lat16_q[$];
    int lat8_q[$];
    longint m16[4];
    longint m8[8];
    bit seen[2];
    bit force16 = 1'b0;
    bit val16 = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural registers.
    task automatic model(input int s, input int op, input int rg, input longint arg,
                         output logic [31:0] e, output int lat);
        int w;
        longint mask, r, a, res, n;
        int cy;
        w = (s == 0) ? 16 : 8;
        mask = (longint'(1) << w) - 1;
        r = (s == 0) ? m16[rg] : m8[rg];
        a = arg & mask;
        cy = 0;
        lat = 1;
        res = 0;
        case (op)
            0: begin res = (r + 1) & mask; cy = (r == mask) ? 1 : 0; end
            1: begin res = (r - 1) & mask; cy = (r == 0) ? 1 : 0; end
            2: res = ~r & mask;
            3: res = r & a;
            4, 5: begin
                n = a & ((s == 0) ? 31 : 15);
                if (n > w) n = w;
                if (n > 0) lat = 1 + int'(n);
                if (op == 4) begin
                    res = (r << n) & mask;
                    cy = (n > 0) ? int'((r >> (w - n)) & 1) : 0;
                end else begin
                    res = r >> n;
                    cy = (n > 0) ? int'((r >> (n - 1)) & 1) : 0;
                end
            end
            6: res = r | a;
            default: res = a;
        endcase
        if (s == 0) m16[rg] = res; else m8[rg] = res;
        e = (32'(res) << 16) | (32'(rg) << 8) | (32'(cy) << 1) | ((res == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic drive(input int s, input logic v, input int op, input int rg, input longint arg);
        if (s == 0) begin
            if16.in_valid = v; if16.in_op = 3'(op); if16.in_reg = 2'(rg); if16.in_arg = 16'(arg);
        end else begin
            if8.in_valid = v; if8.in_op = 3'(op); if8.in_reg = 3'(rg); if8.in_arg = 8'(arg);
        end
    endtask

    // Present a command, wait for acceptance, push the expected response, then scramble inputs.
    task automatic send(input int s, input int op, input int rg, input longint arg);
        int guard;
        logic [31:0] e;
        int lat;
        @(negedge clk);
        drive(s, 1'b1, op, rg, arg);
        guard = 0;
        while (!((s == 0) ? if16.in_ready : if8.in_ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            chk("accept_timeout", 64'd0, 64'd1);
            drive(s, 1'b0, 0, 0, 0);
            return;
        end
        model(s, op, rg, arg, e, lat);
        if (s == 0) begin exp16_q.push_back(e); lat16_q.push_back(cyc + lat); end
        else begin exp8_q.push_back(e); lat8_q.push_back(cyc + lat); end
        @(posedge clk);
        #1;
        drive(s, 1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), longint'($urandom));
    endtask

    task automatic mon(input int s, input logic v, input logic rdy, input logic irdy, input logic [31:0] act);
        logic [31:0] e;
        int l;
        bit empty;
        if (!v) return;
        chk("in_ready_low_in_resp", 64'(irdy), 64'd0);
        if (!seen[s]) begin
            seen[s] = 1'b1;
            empty = (s == 0) ? (lat16_q.size() == 0) : (lat8_q.size() == 0);
            if (!empty) begin
                if (s == 0) l = lat16_q.pop_front(); else l = lat8_q.pop_front();
                chk("latency", 64'(cyc), 64'(l));
            end
        end
        empty = (s == 0) ? (exp16_q.size() == 0) : (exp8_q.size() == 0);
        if (empty) begin
            chk("unexpected_output", 64'(act), 64'hFFFF_FFFF_FFFF_FFFF);
            if (rdy) seen[s] = 1'b0;
            return;
        end
        e = (s == 0) ? exp16_q[0] : exp8_q[0];
        chk(rdy ? "result" : "hold_result", 64'(act), 64'(e));
        if (rdy) begin
            if (s == 0) void'(exp16_q.pop_front()); else void'(exp8_q.pop_front());
            seen[s] = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if16.out_ready = force16 ? val16 : 1'b1;
        if8.out_ready = 1'($urandom_range(0, 1));
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            seen[0] = 1'b0;
            seen[1] = 1'b0;
        end else begin
            mon(0, if16.out_valid, if16.out_ready, if16.in_ready,
                {if16.out_data, 6'd0, if16.out_reg, 6'd0, if16.out_carry, if16.out_zero});
            mon(1, if8.out_valid, if8.out_ready, if8.in_ready,
                {8'd0, if8.out_data, 5'd0, if8.out_reg, 6'd0, if8.out_carry, if8.out_zero});
        end
    end

    task automatic clear_model();
        foreach (m16[i]) m16[i] = 0;
        foreach (m8[i]) m8[i] = 0;
        exp16_q.delete(); exp8_q.delete();
        lat16_q.delete(); lat8_q.delete();
    endtask

    initial begin
        int guard;
        clear_model();
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        if16.out_ready = 1'b1;
        if8.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(if16.out_valid), 64'd0);
        chk("rst_outputs", 64'({if16.out_data, if16.out_reg, if16.out_carry, if16.out_zero}), 64'd0);
        chk("rst_state", 64'(dbg16), 64'(ST_IDLE));
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(if16.in_ready), 64'd1);

        send(0, 7, 1, 'h00F0);
        send(0, 4, 1, 4);
        send(0, 7, 0, 'hFFFF);
        send(0, 0, 0, 0);
        send(0, 1, 0, 0);
        send(0, 7, 2, 'h8001);
        send(0, 5, 2, 20);
        send(0, 2, 1, 0);
        send(0, 3, 1, 'h0FF0);
        send(0, 4, 2, 0);

        // Hold the response for three cycles; the INC must land in r3 only once.
        force16 = 1'b1; val16 = 1'b0;
        send(0, 0, 3, 0);
        guard = 0;
        while (!if16.out_valid && guard < 100) begin @(negedge clk); guard++; end
        repeat (3) @(negedge clk);
        force16 = 1'b0;
        send(0, 6, 3, 0);

        // Reset in the middle of a shift aborts it and clears every register.
        send(0, 7, 3, 'h00FF);
        send(0, 4, 3, 8);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        chk("rst_mid_shift_out_valid", 64'(if16.out_valid), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_abort", 64'(if16.in_ready), 64'd1);
        chk("out_valid_after_abort", 64'(if16.out_valid), 64'd0);
        for (int r = 0; r < 4; r++) send(0, 6, r, 0);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), longint'($urandom_range(0, 255)));
        end

        guard = 0;
        while ((exp16_q.size() != 0 || exp8_q.size() != 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) chk("drain_timeout", 64'(exp16_q.size() + exp8_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath and register width, >= 4.
REQ-002 SHALL have parameter NREGS, default 4: number of internal registers, power of two, >= 2.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1: command present.
REQ-006 SHALL have port in_ready  output  1: core can accept a command.
REQ-007 SHALL have port in_op  input  3: opcode (see REQ-013).
REQ-008 SHALL have port in_reg  input  $clog2(NREGS): target register index.
REQ-009 SHALL have port in_arg  input  WIDTH: mask, load value or shift amount.
REQ-010 SHALL have port out_valid  output  1: result present.
REQ-011 SHALL have port out_ready  input  1: consumer accepts result.
REQ-012 SHALL have ports out_data (WIDTH), out_reg ($clog2(NREGS)), out_carry (1) and out_zero (1), all outputs: result, its register index, carry/borrow, result==0.

Function
REQ-013 SHALL implement opcodes on R=reg[in_reg]: 000 INC R+1; 001 DEC R-1; 010 NOT ~R; 011 AND R&arg; 100 SHL R<<n; 101 SHR R>>n (logical); 110 OR R|arg; 111 LOAD arg.
REQ-014 SHALL accept a command on the cycle in_valid && in_ready are both high; commands are never dropped or duplicated.
REQ-015 SHALL use FSM states IDLE, SHIFT, RESP; in_ready is high only in IDLE; out_valid is high only in RESP.
REQ-016 IDLE on accept SHALL go to SHIFT for SHL/SHR with n>0, else compute result and go to RESP.
REQ-017 SHIFT SHALL shift the working value one bit per cycle, decrementing a counter, and go to RESP the cycle the counter reaches 0.
REQ-018 Shift amount n SHALL be in_arg[$clog2(WIDTH):0] clamped to WIDTH; n>=WIDTH yields 0.
REQ-019 RESP SHALL hold out_data/out_reg/out_carry/out_zero stable until out_ready high, then return to IDLE on that edge.
REQ-020 Latency accept->out_valid SHALL be 1 cycle for non-shift ops and shift with n=0, and 1+n cycles for shifts with n>0.
REQ-021 Target register SHALL be written with the result on the edge entering RESP; out_data equals the new register value.
REQ-022 out_carry SHALL be: INC carry-out (R=all-ones); DEC borrow (R=0); SHL/SHR last bit shifted out (0 if n=0); 0 for all other ops.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH (INC all-ones->0, DEC 0->all-ones).
REQ-024 Back-to-back commands SHALL see register writes from prior commands (no stale reads); next accept earliest the cycle after RESP exit.
REQ-025 in_op/in_reg/in_arg SHALL be sampled only at accept; changes afterwards have no effect.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, all registers 0, out_valid 0, out_data 0, out_reg 0, out_carry 0, out_zero 0, shift counter 0.
REQ-027 Reset mid-SHIFT or mid-RESP SHALL abort the command with no register write beyond values already committed; in_ready high the first cycle after rst_n deasserts.

Structure
REQ-028 Package alu_pkg SHALL hold the opcode enum (OP_INC..OP_LOAD) and the FSM state enum.
REQ-029 Register file SHALL be a sub-module alu_regfile (one async read port, one write port, parameters WIDTH/NREGS, async active-low reset to 0).

Verification
REQ-030 LOAD r1 0x00F0, SHL r1 n=4 -> out_valid 5 cycles after accept, out_data 0x0F00, carry 0, zero 0.
REQ-031 LOAD r0 0xFFFF, INC r0 -> out_data 0x0000, carry 1, zero 1; DEC r0 -> 0xFFFF, carry 1.
REQ-032 LOAD r2 0x8001, SHR r2 n=20 (clamped 16) -> out_data 0x0000, zero 1, carry 1 (bit 15 last out).
REQ-033 RESP with out_ready low for 3 cycles -> outputs stable, in_ready 0, register written once.
REQ-034 rst_n low during SHIFT of SHL r3 n=8 -> out_valid 0, all registers 0, in_ready 1 first cycle after release.
REQ-035 Random op stream, WIDTH=8 NREGS=8, random in_valid/out_ready -> results match reference model.
